// File: rtl/usb_bulk_pkg.sv
// Shared definitions for the bulk-IN endpoint mux: FSM encoding,
// max-packet sizes and the per-transaction byte counter width.
package usb_bulk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int MAX_PKT_HS = 512;
    localparam int MAX_PKT_FS = 64;
    localparam int CNT_W      = 10;

endpackage

// File: rtl/usb_bulk_in_mux.sv
// Routes one of NUM_EP AXI-S endpoint sources onto the bid_* bulk-IN port.
// Define USB_BULK_IN_LIMIT_EN to cut packets at MAX_PACKET bytes.
module usb_bulk_in_mux
    import usb_bulk_pkg::*;
#(
    parameter int NUM_EP     = 2,
    parameter int EP_BASE    = 1,
    parameter int MAX_PACKET = MAX_PKT_HS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                blk_in_xfer_i,
    input  logic [3:0]          blk_xfer_endpoint_i,
    input  logic [NUM_EP-1:0]   src_has_data_i,
    input  logic [NUM_EP-1:0]   src_tvalid_i,
    output logic [NUM_EP-1:0]   src_tready_o,
    input  logic [NUM_EP-1:0]   src_tlast_i,
    input  logic [8*NUM_EP-1:0] src_tdata_i,
    output logic                bid_has_data_o,
    output logic                bid_tvalid_o,
    input  logic                bid_tready_i,
    output logic                bid_tlast_o,
    output logic [7:0]          bid_tdata_o,
    output logic [3:0]          sel_ep_o,
    output logic                busy_o
);

    localparam int IDX_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

`ifdef USB_BULK_IN_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t             state, state_n;
    logic [IDX_W-1:0]   sel_idx, dec_idx;
    logic [3:0]         sel_ep;
    logic [CNT_W-1:0]   count, count_n;
    logic               dec_in_range;
    logic               sel_valid, sel_last, limit_hit, handshake, tlast_now;
    logic [7:0]         sel_byte;

    // Endpoint decode must be combinational so has_data answers in the sampling cycle.
    assign dec_idx      = IDX_W'(blk_xfer_endpoint_i - 4'(EP_BASE));
    assign dec_in_range = (int'(blk_xfer_endpoint_i) >= EP_BASE) &&
                          (int'(blk_xfer_endpoint_i) <  EP_BASE + NUM_EP);

    assign bid_has_data_o = dec_in_range & src_has_data_i[dec_idx];

    assign limit_hit = LIMIT_EN && (count == CNT_W'(MAX_PACKET - 1));

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = 8'h00;
        for (int i = 0; i < NUM_EP; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_valid = src_tvalid_i[i];
                sel_last  = src_tlast_i[i];
                sel_byte  = src_tdata_i[i*8 +: 8];
            end
        end
    end

    // A dropped blk_in_xfer_i gates the handshake at once, so no byte is lost on abort.
    always_comb begin
        state_n      = state;
        bid_tvalid_o = 1'b0;
        bid_tlast_o  = 1'b0;
        bid_tdata_o  = 8'h00;
        src_tready_o = '0;
        handshake    = 1'b0;
        tlast_now    = 1'b0;
        case (state)
            IDLE: begin
                if (blk_in_xfer_i) begin
                    state_n = dec_in_range ? STREAM : DRAIN;
                end
            end
            STREAM: begin
                tlast_now   = sel_last | limit_hit;
                bid_tdata_o = sel_byte;
                bid_tlast_o = tlast_now;
                if (!blk_in_xfer_i) begin
                    state_n = IDLE;
                end else begin
                    bid_tvalid_o = sel_valid;
                    for (int i = 0; i < NUM_EP; i++) begin
                        src_tready_o[i] = (IDX_W'(i) == sel_idx) & bid_tready_i;
                    end
                    handshake = sel_valid & bid_tready_i;
                    if (handshake && tlast_now) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!blk_in_xfer_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        count_n = count;
        if (state_n == IDLE) begin
            count_n = '0;
        end else if (handshake) begin
            count_n = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_idx <= '0;
            sel_ep  <= 4'd0;
            count   <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (state == IDLE && blk_in_xfer_i) begin
                sel_idx <= dec_idx;
                sel_ep  <= blk_xfer_endpoint_i;
            end
        end
    end

    assign sel_ep_o = sel_ep;
    assign busy_o   = (state != IDLE);

endmodule

// File: tb/tb_usb_bulk_in_mux.sv
// Self-checking bench for usb_bulk_in_mux: per-source byte queues act as the
// endpoint FIFOs and as the reference for what each IN transaction must deliver.
module tb_usb_bulk_in_mux;

    localparam int NUM_EP     = 2;
    localparam int EP_BASE    = 1;
    localparam int MAX_PACKET = 512;

`ifdef USB_BULK_IN_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                blk_in_xfer_i;
    logic [3:0]          blk_xfer_endpoint_i;
    logic [NUM_EP-1:0]   src_has_data_i;
    logic [NUM_EP-1:0]   src_tvalid_i;
    logic [NUM_EP-1:0]   src_tready_o;
    logic [NUM_EP-1:0]   src_tlast_i;
    logic [8*NUM_EP-1:0] src_tdata_i;
    logic                bid_has_data_o;
    logic                bid_tvalid_o;
    logic                bid_tready_i;
    logic                bid_tlast_o;
    logic [7:0]          bid_tdata_o;
    logic [3:0]          sel_ep_o;
    logic                busy_o;

    usb_bulk_in_mux #(
        .NUM_EP     (NUM_EP),
        .EP_BASE    (EP_BASE),
        .MAX_PACKET (MAX_PACKET)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .blk_in_xfer_i       (blk_in_xfer_i),
        .blk_xfer_endpoint_i (blk_xfer_endpoint_i),
        .src_has_data_i      (src_has_data_i),
        .src_tvalid_i        (src_tvalid_i),
        .src_tready_o        (src_tready_o),
        .src_tlast_i         (src_tlast_i),
        .src_tdata_i         (src_tdata_i),
        .bid_has_data_o      (bid_has_data_o),
        .bid_tvalid_o        (bid_tvalid_o),
        .bid_tready_i        (bid_tready_i),
        .bid_tlast_o         (bid_tlast_o),
        .bid_tdata_o         (bid_tdata_o),
        .sel_ep_o            (sel_ep_o),
        .busy_o              (busy_o)
    );

    always #5 clk = ~clk;

    // Each entry is {last, byte}; one queue per endpoint source.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int errors = 0;
    int checks = 0;

    function automatic int sizeOf(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [8:0] headOf(input int s);
        if (s == 0) return (q0.size() > 0) ? q0[0] : 9'h000;
        return (q1.size() > 0) ? q1[0] : 9'h000;
    endfunction

    task automatic popSrc(input int s);
        if (s == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic loadPacket(input int s, input int len, input bit randData, input logic [7:0] base);
        logic [8:0] e;
        for (int i = 0; i < len; i++) begin
            e[7:0] = randData ? 8'($urandom_range(0, 255)) : base + 8'(i);
            e[8]   = (i == len - 1);
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit randValid, input bit randReady);
        logic [8:0] h;
        for (int s = 0; s < NUM_EP; s++) begin
            h = headOf(s);
            src_has_data_i[s]     = (sizeOf(s) > 0);
            src_tvalid_i[s]       = (sizeOf(s) > 0) && (!randValid || ($urandom_range(0, 3) != 0));
            src_tlast_i[s]        = h[8];
            src_tdata_i[s*8 +: 8] = h[7:0];
        end
        bid_tready_i = !randReady || ($urandom_range(0, 3) != 0);
    endtask

    // One IN transaction; abortAfter >= 0 drops blk_in_xfer_i after that many bytes.
    task automatic runXfer(input logic [3:0] ep, input bit randMode, input int abortAfter, output int nBytes);
        int         s;
        bit         inRange, done, hs, expLast, expValid;
        int         pos, cyc;
        logic [8:0] h;
        logic [1:0] expReady;
        s       = int'(ep) - EP_BASE;
        inRange = (int'(ep) >= EP_BASE) && (int'(ep) < EP_BASE + NUM_EP);
        pos     = 0;
        cyc     = 0;
        done    = 1'b0;
        @(negedge clk);
        blk_xfer_endpoint_i = ep;
        blk_in_xfer_i       = 1'b1;
        applyStimulus(randMode, randMode);
        #1;
        checkOutput("has_data", 32'(bid_has_data_o), 32'(inRange && sizeOf(s) > 0));
        checkOutput("idle_tready", 32'(src_tready_o), 32'd0);
        @(posedge clk);
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            hs      = 1'b0;
            expLast = 1'b0;
            if (randMode) blk_xfer_endpoint_i = 4'($urandom_range(0, 15));
            applyStimulus(randMode, randMode);
            if (abortAfter >= 0 && pos == abortAfter) begin
                blk_in_xfer_i = 1'b0;
                bid_tready_i  = 1'b0;
                done          = 1'b1;
            end
            #1;
            if (!done) begin
                checkOutput("sel_ep", 32'(sel_ep_o), 32'(ep));
                checkOutput("busy", 32'(busy_o), 32'd1);
                if (inRange) begin
                    h        = headOf(s);
                    expValid = src_tvalid_i[s];
                    expReady = 2'b00;
                    if (bid_tready_i) expReady[s] = 1'b1;
                    checkOutput("tvalid", 32'(bid_tvalid_o), 32'(expValid));
                    checkOutput("tready", 32'(src_tready_o), 32'(expReady));
                    if (expValid) begin
                        expLast = h[8] || (LIMIT && pos == MAX_PACKET - 1);
                        checkOutput("tdata", 32'(bid_tdata_o), 32'(h[7:0]));
                        checkOutput("tlast", 32'(bid_tlast_o), 32'(expLast));
                        hs = bid_tready_i;
                    end
                end else begin
                    checkOutput("oor_tvalid", 32'(bid_tvalid_o), 32'd0);
                    checkOutput("oor_tready", 32'(src_tready_o), 32'd0);
                    if (cyc == 3) done = 1'b1;
                end
            end
            @(posedge clk);
            if (hs) begin
                popSrc(s);
                pos++;
                if (expLast) done = 1'b1;
            end
        end
        checkOutput("xfer_done", 32'(done), 32'd1);
        if (abortAfter >= 0) begin
            @(negedge clk);
            bid_tready_i = 1'b1;
            #1;
            checkOutput("abort_tready", 32'(src_tready_o), 32'd0);
            checkOutput("abort_busy", 32'(busy_o), 32'd0);
        end else begin
            repeat (2) begin
                @(negedge clk);
                applyStimulus(1'b0, 1'b0);
                #1;
                checkOutput("drain_busy", 32'(busy_o), 32'd1);
                checkOutput("drain_tvalid", 32'(bid_tvalid_o), 32'd0);
                checkOutput("drain_tready", 32'(src_tready_o), 32'd0);
            end
            @(negedge clk);
            blk_in_xfer_i = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("idle_busy", 32'(busy_o), 32'd0);
        end
        nBytes = pos;
    endtask

    initial begin
        int n;
        int xfers;
        int lens[4];
        rst                 = 1'b1;
        blk_in_xfer_i       = 1'b0;
        blk_xfer_endpoint_i = 4'd0;
        src_has_data_i      = '0;
        src_tvalid_i        = '0;
        src_tlast_i         = '0;
        src_tdata_i         = '0;
        bid_tready_i        = 1'b0;
        #12;
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_tvalid", 32'(bid_tvalid_o), 32'd0);
        checkOutput("rst_tready", 32'(src_tready_o), 32'd0);
        checkOutput("rst_tlast", 32'(bid_tlast_o), 32'd0);
        checkOutput("rst_tdata", 32'(bid_tdata_o), 32'd0);
        checkOutput("rst_sel_ep", 32'(sel_ep_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic 5-byte packet on EP2");
        loadPacket(1, 5, 1'b0, 8'hA0);
        runXfer(4'd2, 1'b0, -1, n);
        checkOutput("t1_len", 32'(n), 32'd5);

        $display("[TB] out-of-range endpoint 5");
        loadPacket(0, 3, 1'b0, 8'h10);
        runXfer(4'd5, 1'b0, -1, n);
        checkOutput("t2_len", 32'(n), 32'd0);
        q0.delete();

        $display("[TB] 600-byte packet on EP1, random flow control");
        loadPacket(0, 600, 1'b1, 8'h00);
        xfers = 0;
        while (q0.size() > 0 && xfers < 4) begin
            runXfer(4'd1, 1'b1, -1, n);
            lens[xfers] = n;
            xfers++;
        end
        checkOutput("t3_xfers", 32'(xfers), LIMIT ? 32'd2 : 32'd1);
        checkOutput("t3_first_len", 32'(lens[0]), LIMIT ? 32'd512 : 32'd600);
        checkOutput("t3_last_len", 32'(lens[xfers-1]), LIMIT ? 32'd88 : 32'd600);

        $display("[TB] abort after 3 of 10 bytes, then resume");
        loadPacket(1, 10, 1'b0, 8'h30);
        runXfer(4'd2, 1'b0, 3, n);
        checkOutput("t4_abort_len", 32'(n), 32'd3);
        runXfer(4'd2, 1'b0, -1, n);
        checkOutput("t4_resume_len", 32'(n), 32'd7);

        $display("[TB] async reset mid-stream");
        loadPacket(0, 5, 1'b0, 8'h50);
        @(negedge clk);
        blk_xfer_endpoint_i = 4'd1;
        blk_in_xfer_i       = 1'b1;
        applyStimulus(1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("t5_pre_busy", 32'(busy_o), 32'd1);
        checkOutput("t5_pre_tvalid", 32'(bid_tvalid_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_busy", 32'(busy_o), 32'd0);
        checkOutput("t5_tvalid", 32'(bid_tvalid_o), 32'd0);
        checkOutput("t5_tready", 32'(src_tready_o), 32'd0);
        checkOutput("t5_tlast", 32'(bid_tlast_o), 32'd0);
        checkOutput("t5_tdata", 32'(bid_tdata_o), 32'd0);
        checkOutput("t5_sel_ep", 32'(sel_ep_o), 32'd0);
        blk_in_xfer_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
